ysyx_22041071_regfile: RTL and testbench

YSYX_22041071_REGFILE -- requirements
Module: ysyx_22041071_regfile

---
 rtl/ysyx_22041071_regfile_pkg.sv | 18 +
 rtl/ysyx_22041071_commit_buf.sv | 86 ++++++++
 rtl/ysyx_22041071_regfile.sv | 91 +++++++++
 tb/tb_ysyx_22041071_regfile.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041071_regfile_pkg.sv
// Shared widths and types for the ysyx_22041071 register file and its
// commit buffer. Register/data width, register count, index width and the
// commit-record field widths all live here.
package ysyx_22041071_regfile_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREG_DEF  = 32;
  localparam int REG_IDX_W = 5;
  localparam int PC_W      = 64;
  localparam int INS_W     = 32;
  localparam int CNT_W     = 64;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/ysyx_22041071_commit_buf.sv
// One-entry commit buffer between write-back and the difftest consumer.
// Accepts a record whenever it is empty or the held record is being
// consumed in the same cycle, so a steady stream flows without bubbles.
module ysyx_22041071_commit_buf
  import ysyx_22041071_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [INS_W-1:0]     in_ins,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_wen,
  input  logic [XLEN-1:0]      in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [INS_W-1:0]     out_ins,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_wen,
  output logic [XLEN-1:0]      out_data
);

  buf_state_e           state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INS_W-1:0]     ins_q, ins_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic                 wen_q, wen_d;
  logic [XLEN-1:0]      data_q, data_d;
  logic                 fire;

  // Handshake: ready never looks at in_valid, only at occupancy and drain.
  always_comb begin
    in_ready  = (state_q == BUF_EMPTY) || out_ready;
    fire      = in_valid && in_ready;
    out_valid = (state_q == BUF_FULL);
    out_pc    = pc_q;
    out_ins   = ins_q;
    out_rd    = rd_q;
    out_wen   = wen_q;
    out_data  = data_q;
  end

  // Next state: a new record always wins (overwrite-while-draining keeps FULL).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    data_d  = data_q;
    if (fire) begin
      state_d = BUF_FULL;
      pc_d    = in_pc;
      ins_d   = in_ins;
      rd_d    = in_rd;
      wen_d   = in_wen;
      data_d  = in_data;
    end else if ((state_q == BUF_FULL) && out_ready) begin
      state_d = BUF_EMPTY;
    end
  end

  // State and record registers; reset discards any buffered record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BUF_EMPTY;
      pc_q    <= '0;
      ins_q   <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/ysyx_22041071_regfile.sv
// Architectural integer register file with write-back handshake, a
// one-entry commit record for difftest, and a retired-instruction counter.
// Optional feature: define YSYX_22041071_REGFILE_BYPASS_EN to forward the
// write-back data being accepted this cycle onto matching read ports.
module ysyx_22041071_regfile
  import ysyx_22041071_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [PC_W-1:0]      wb_pc,
  input  logic [INS_W-1:0]     wb_ins,
  input  logic                 wb_wen,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic [REG_IDX_W-1:0] rs1_addr,
  input  logic [REG_IDX_W-1:0] rs2_addr,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  output logic                 commit_valid,
  input  logic                 commit_ready,
  output logic [PC_W-1:0]      commit_pc,
  output logic [INS_W-1:0]     commit_ins,
  output logic [REG_IDX_W-1:0] commit_rd,
  output logic                 commit_wen,
  output logic [XLEN-1:0]      commit_data,
  output logic [CNT_W-1:0]     commit_cnt
);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wb_fire;
  logic             wr_en;

  ysyx_22041071_commit_buf #(.XLEN(XLEN)) u_commit_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (wb_valid),
    .in_ready  (wb_ready),
    .in_pc     (wb_pc),
    .in_ins    (wb_ins),
    .in_rd     (wb_rd),
    .in_wen    (wb_wen),
    .in_data   (wb_data),
    .out_valid (commit_valid),
    .out_ready (commit_ready),
    .out_pc    (commit_pc),
    .out_ins   (commit_ins),
    .out_rd    (commit_rd),
    .out_wen   (commit_wen),
    .out_data  (commit_data)
  );

  // Register update and retire count; x0 writes are dropped but still counted.
  always_comb begin
    wb_fire = wb_valid && wb_ready;
    wr_en   = wb_fire && wb_wen && (wb_rd != '0);
    regs_d  = regs_q;
    if (wr_en) regs_d[wb_rd] = wb_data;
    cnt_d = cnt_q;
    if (wb_fire) cnt_d = cnt_q + CNT_W'(1);
  end

  // Combinational read ports, x0 hard-wired to zero.
  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
`ifdef YSYX_22041071_REGFILE_BYPASS_EN
    if (wr_en && (wb_rd == rs1_addr)) rs1_data = wb_data;
    if (wr_en && (wb_rd == rs2_addr)) rs2_data = wb_data;
`endif
    commit_cnt = cnt_q;
  end

  // Register array and counter state, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_regfile.sv
// Scoreboard bench for ysyx_22041071_regfile: the driver pushes each
// accepted write-back as an expected commit record, a monitor pops and
// compares on every commit handshake; read ports and counter are checked
// against a small register model in the driver.
module tb_ysyx_22041071_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_pc;
  logic [31:0] wb_ins;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [63:0] rs1_data, rs2_data;
  logic        commit_valid;
  logic        commit_ready;
  logic [63:0] commit_pc;
  logic [31:0] commit_ins;
  logic [4:0]  commit_rd;
  logic        commit_wen;
  logic [63:0] commit_data;
  logic [63:0] commit_cnt;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] data;
  } rec_t;

  rec_t        exp_q[$];
  logic [63:0] exp_regs [32];
  logic [63:0] exp_cnt;
  int          n_vec = 0;
  int          n_err = 0;

  ysyx_22041071_regfile dut (
    .clk          (clk),
    .reset        (reset),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_pc        (wb_pc),
    .wb_ins       (wb_ins),
    .wb_wen       (wb_wen),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .commit_pc    (commit_pc),
    .commit_ins   (commit_ins),
    .commit_rd    (commit_rd),
    .commit_wen   (commit_wen),
    .commit_data  (commit_data),
    .commit_cnt   (commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_accept(input logic [63:0] pc, input logic [31:0] ins,
                              input logic wen, input logic [4:0] rd, input logic [63:0] data);
    rec_t r;
    r.pc = pc; r.ins = ins; r.rd = rd; r.wen = wen; r.data = data;
    exp_q.push_back(r);
    if (wen && rd != 5'd0) exp_regs[rd] = data;
    exp_cnt = exp_cnt + 64'd1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_regs[i] = 64'd0;
    exp_cnt = 64'd0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [63:0] pc, input logic [31:0] ins,
                      input logic wen, input logic [4:0] rd, input logic [63:0] data);
    int n = 0;
    wb_valid = 1'b1; wb_pc = pc; wb_ins = ins; wb_wen = wen; wb_rd = rd; wb_data = data;
    @(negedge clk);
    while (!wb_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!wb_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: wb_ready stuck at %b, expected 1", wb_ready);
    end else begin
      model_accept(pc, ins, wen, rd, data);
    end
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  // Monitor: compare every commit handshake against the scoreboard queue.
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (reset && commit_valid && commit_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_commit: got pc %h, expected no record", commit_pc);
        end else begin
          e = exp_q.pop_front();
          chk("mon_pc",   commit_pc,   e.pc);
          chk("mon_ins",  {32'd0, commit_ins}, {32'd0, e.ins});
          chk("mon_rd",   {59'd0, commit_rd},  {59'd0, e.rd});
          chk("mon_wen",  {63'd0, commit_wen}, {63'd0, e.wen});
          chk("mon_data", commit_data, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t, expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; wb_valid = 1'b0; wb_pc = '0; wb_ins = '0; wb_wen = 1'b0;
    wb_rd = '0; wb_data = '0; rs1_addr = 5'd5; rs2_addr = 5'd0; commit_ready = 1'b1;
    model_reset();

    // Reset held
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_commit_valid", {63'd0, commit_valid}, 64'd0);
    chk("rst_commit_cnt", commit_cnt, 64'd0);
    chk("rst_commit_pc", commit_pc, 64'd0);
    chk("rst_rs1", rs1_data, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_wb_ready", {63'd0, wb_ready}, 64'd1);
    @(posedge clk); #1;

    // x5 = 0x1234
    send(64'h8000_0000, 32'h0000_0293, 1'b1, 5'd5, 64'h1234);
    rs1_addr = 5'd5;
    @(negedge clk);
    chk("x5_read", rs1_data, 64'h1234);
    chk("x5_commit_pc", commit_pc, 64'h8000_0000);
    chk("x5_commit_cnt", commit_cnt, exp_cnt);
    chk("x5_cnt_is_1", commit_cnt, 64'd1);
    @(posedge clk); #1;

    // x0 write dropped, still retired
    send(64'h8000_0004, 32'h0000_0013, 1'b1, 5'd0, 64'hFFFF);
    rs1_addr = 5'd0;
    @(negedge clk);
    chk("x0_read", rs1_data, 64'd0);
    chk("x0_commit_rd", {59'd0, commit_rd}, 64'd0);
    chk("x0_commit_wen", {63'd0, commit_wen}, 64'd1);
    chk("x0_commit_cnt", commit_cnt, 64'd2);
    @(posedge clk); #1;

    // Back-to-back writes, including a wen=0 retire
    send(64'h8000_0008, 32'h1111_1111, 1'b1, 5'd1,  64'hDEAD_BEEF_0000_0001);
    send(64'h8000_000C, 32'h2222_2222, 1'b1, 5'd31, 64'h8000_0000_0000_0000);
    send(64'h8000_0010, 32'h3333_3333, 1'b0, 5'd1,  64'h0BAD_0BAD_0BAD_0BAD);
    rs1_addr = 5'd1; rs2_addr = 5'd31;
    @(negedge clk);
    chk("x1_read", rs1_data, exp_regs[1]);
    chk("x1_value", rs1_data, 64'hDEAD_BEEF_0000_0001);
    chk("x31_read", rs2_data, 64'h8000_0000_0000_0000);
    chk("cnt_5", commit_cnt, 64'd5);
    repeat (2) @(posedge clk); #1;

    // Backpressure: record stable while consumer stalls, then overwrite
    commit_ready = 1'b0;
    send(64'h8000_0100, 32'hAAAA_0001, 1'b1, 5'd2, 64'h2222);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_wb_ready", {63'd0, wb_ready}, 64'd0);
      chk("stall_commit_valid", {63'd0, commit_valid}, 64'd1);
      chk("stall_commit_pc", commit_pc, 64'h8000_0100);
      chk("stall_commit_data", commit_data, 64'h2222);
    end
    @(posedge clk); #1;
    commit_ready = 1'b1;
    send(64'h8000_0104, 32'hAAAA_0002, 1'b1, 5'd3, 64'h3333);
    @(negedge clk);
    chk("ovr_commit_valid", {63'd0, commit_valid}, 64'd1);
    chk("ovr_commit_pc", commit_pc, 64'h8000_0104);
    @(posedge clk); #1;

    // Same-cycle read of the register being written
    send(64'h8000_0200, 32'h0000_0393, 1'b1, 5'd7, 64'h0000_0000_0000_0777);
    rs2_addr = 5'd7;
    wb_valid = 1'b1; wb_pc = 64'h8000_0204; wb_ins = 32'h0000_0394;
    wb_wen = 1'b1; wb_rd = 5'd7; wb_data = 64'h5555_AAAA_5555_AAAA;
    @(negedge clk);
    chk("byp_wb_ready", {63'd0, wb_ready}, 64'd1);
`ifdef YSYX_22041071_REGFILE_BYPASS_EN
    chk("byp_rs2", rs2_data, 64'h5555_AAAA_5555_AAAA);
`else
    chk("byp_rs2", rs2_data, 64'h0000_0000_0000_0777);
`endif
    chk("byp_rs1_x1", (rs1_addr == 5'd1) ? rs1_data : 64'd0, 64'hDEAD_BEEF_0000_0001);
    if (wb_ready) model_accept(wb_pc, wb_ins, wb_wen, wb_rd, wb_data);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    @(negedge clk);
    chk("byp_after", rs2_data, exp_regs[7]);
    @(posedge clk); #1;

    // Counter wrap
    force dut.cnt_d = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    release dut.cnt_d;
    exp_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("cnt_preload", commit_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    send(64'h8000_0300, 32'h0000_0001, 1'b1, 5'd4, 64'h4444);
    @(negedge clk);
    chk("cnt_wrap", commit_cnt, 64'd0);
    @(posedge clk); #1;

    // Reset while FULL
    commit_ready = 1'b0;
    send(64'h8000_0400, 32'h0000_0002, 1'b1, 5'd6, 64'h6666);
    rs1_addr = 5'd6;
    @(negedge clk);
    chk("pre_rst_full", {63'd0, commit_valid}, 64'd1);
    chk("pre_rst_x6", rs1_data, 64'h6666);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("async_rst_commit_valid", {63'd0, commit_valid}, 64'd0);
    chk("async_rst_cnt", commit_cnt, 64'd0);
    chk("async_rst_commit_pc", commit_pc, 64'd0);
    chk("async_rst_x6", rs1_data, 64'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    commit_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      #1;
      chk("post_rst_reg", rs1_data, exp_regs[i]);
    end
    @(negedge clk);
    chk("post_rst_commit_valid", {63'd0, commit_valid}, 64'd0);
    chk("post_rst_ready", {63'd0, wb_ready}, 64'd1);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
